// File: rtl/logic_op_issue.sv
// Issue/retire stage around the N-bit logical unit: request FIFO, head presentation, registered result.
// Optional macro LOGIC_OP_PARITY_EN adds a registered out_parity output.
module logic_op_issue #(
    parameter int unsigned N     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N-1:0]             in_a,
    input  logic [N-1:0]             in_b,
    input  logic [1:0]               in_op,
    output logic [N-1:0]             lu_a,
    output logic [N-1:0]             lu_b,
    output logic [1:0]               lu_op,
    input  logic [N-1:0]             lu_r,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_r,
    output logic [1:0]               out_op,
    output logic                     out_zero,
`ifdef LOGIC_OP_PARITY_EN
    output logic                     out_parity,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic {O_EMPTY = 1'b0, O_FULL = 1'b1} ostate_t;

    logic [N-1:0]  mem_a  [DEPTH];
    logic [N-1:0]  mem_b  [DEPTH];
    logic [1:0]    mem_op [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    ostate_t       state;
    logic          push;
    logic          load;
    logic          not_empty;

    assign not_empty = (count != CW'(0));
    assign in_ready  = (count != CW'(DEPTH)) && !rst;
    assign push      = in_valid && in_ready;
    assign load      = not_empty && ((state == O_EMPTY) || out_ready);
    assign out_valid = (state == O_FULL);

    // Head entry goes straight from storage to the logical unit; zeros when empty.
    assign lu_a  = not_empty ? mem_a[rd_ptr]  : '0;
    assign lu_b  = not_empty ? mem_b[rd_ptr]  : '0;
    assign lu_op = not_empty ? mem_op[rd_ptr] : 2'b00;

    // Storage carries no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]  <= in_a;
            mem_b[wr_ptr]  <= in_b;
            mem_op[wr_ptr] <= in_op;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (load) rd_ptr <= rd_ptr + PW'(1);
            case ({push, load})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Output stage: capture on load, drain when accepted, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= O_EMPTY;
            out_r      <= '0;
            out_op     <= 2'b00;
            out_zero   <= 1'b0;
`ifdef LOGIC_OP_PARITY_EN
            out_parity <= 1'b0;
`endif
        end else if (load) begin
            state      <= O_FULL;
            out_r      <= lu_r;
            out_op     <= lu_op;
            out_zero   <= (lu_r == '0);
`ifdef LOGIC_OP_PARITY_EN
            out_parity <= ^lu_r;
`endif
        end else if ((state == O_FULL) && out_ready) begin
            state <= O_EMPTY;
        end
    end

endmodule

// File: tb/tb_logic_op_issue.sv
// Bench for logic_op_issue: queue-based reference model checked every cycle plus directed literal checks.
module tb_logic_op_issue;

    localparam int unsigned N     = 8;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_a = '0;
    logic [N-1:0] in_b = '0;
    logic [1:0]   in_op = 2'b00;
    logic [N-1:0] lu_a;
    logic [N-1:0] lu_b;
    logic [1:0]   lu_op;
    logic [N-1:0] lu_r;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_r;
    logic [1:0]   out_op;
    logic         out_zero;
`ifdef LOGIC_OP_PARITY_EN
    logic         out_parity;
`endif
    logic [2:0]   count;

    int checks   = 0;
    int failures = 0;
    bit running  = 1'b0;

    logic_op_issue #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op),
        .lu_a(lu_a), .lu_b(lu_b), .lu_op(lu_op), .lu_r(lu_r),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_op(out_op), .out_zero(out_zero),
`ifdef LOGIC_OP_PARITY_EN
        .out_parity(out_parity),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] lfun(input logic [N-1:0] a, input logic [N-1:0] b,
                                          input logic [1:0] op);
        case (op)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~(a | b);
        endcase
    endfunction

    // Logical unit stand-in driven by the DUT head.
    assign lu_r = lfun(lu_a, lu_b, lu_op);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending requests as a queue, one result slot.
    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [1:0]   op;
    } req_t;

    req_t         q[$];
    bit           m_valid = 1'b0;
    logic [N-1:0] m_r = '0;
    logic [1:0]   m_op = 2'b00;
    bit           m_zero = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_valid = 1'b0;
            m_r = '0;
            m_op = 2'b00;
            m_zero = 1'b0;
        end else begin
            bit   do_push;
            bit   do_pop;
            req_t h;
            do_push = in_valid && (q.size() < DEPTH);
            do_pop  = (q.size() > 0) && (!m_valid || out_ready);
            if (do_pop) begin
                h = q.pop_front();
                m_r = lfun(h.a, h.b, h.op);
                m_op = h.op;
                m_zero = (m_r == '0);
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            if (do_push) q.push_back('{a: in_a, b: in_b, op: in_op});
        end
    end

    always @(negedge clk) begin
        if (running) begin
            chk("in_ready", 32'(in_ready), 32'((q.size() < DEPTH) && !rst));
            chk("count", 32'(count), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_r", 32'(out_r), 32'(m_r));
            chk("out_op", 32'(out_op), 32'(m_op));
            chk("out_zero", 32'(out_zero), 32'(m_zero));
`ifdef LOGIC_OP_PARITY_EN
            chk("out_parity", 32'(out_parity), 32'(^m_r));
`endif
            if (q.size() > 0) begin
                chk("lu_a", 32'(lu_a), 32'(q[0].a));
                chk("lu_b", 32'(lu_b), 32'(q[0].b));
                chk("lu_op", 32'(lu_op), 32'(q[0].op));
            end else begin
                chk("lu_idle", 32'({lu_a, lu_b, lu_op}), 32'(0));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic push_one(input logic [N-1:0] a, input logic [N-1:0] b, input logic [1:0] op);
        bit done;
        done = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        chk("push_accept", 32'(done), 32'(1));
    endtask

    initial begin
        running = 1'b1;
        rst = 1'b1;
        step();
        chk("rst_in_ready", 32'(in_ready), 32'(0));
        step();
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_out_r", 32'(out_r), 32'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'(1));

        // Single AND; result visible two cycles after accept.
        out_ready = 1'b1;
        push_one(8'hF0, 8'h3C, 2'b00);
        chk("and_t1_valid", 32'(out_valid), 32'(0));
        chk("and_t1_count", 32'(count), 32'(1));
        step();
        chk("and_t2_valid", 32'(out_valid), 32'(1));
        chk("and_r", 32'(out_r), 32'h30);
        chk("and_op", 32'(out_op), 32'(0));
        chk("and_zero", 32'(out_zero), 32'(0));
        chk("and_count", 32'(count), 32'(0));
        step();
        chk("and_drained", 32'(out_valid), 32'(0));

        // Back-to-back stream, one result per cycle.
        push_one(8'h5A, 8'h5A, 2'b10);
        push_one(8'h00, 8'h00, 2'b11);
        chk("b2b_xor_r", 32'(out_r), 32'h00);
        chk("b2b_xor_zero", 32'(out_zero), 32'(1));
        push_one(8'h81, 8'h18, 2'b01);
        chk("b2b_nor_r", 32'(out_r), 32'hFF);
        chk("b2b_nor_zero", 32'(out_zero), 32'(0));
        step();
        chk("b2b_or_r", 32'(out_r), 32'h99);
        chk("b2b_or_op", 32'(out_op), 32'(1));
        step();
        chk("b2b_drained", 32'(out_valid), 32'(0));

        // Backpressure: fill output stage plus FIFO.
        out_ready = 1'b0;
        push_one(8'hFF, 8'h0F, 2'b00);
        push_one(8'h10, 8'h01, 2'b01);
        push_one(8'hAA, 8'hFF, 2'b10);
        push_one(8'hF0, 8'h0F, 2'b11);
        push_one(8'hC3, 8'h81, 2'b00);
        chk("bp_count", 32'(count), 32'(4));
        chk("bp_held_r", 32'(out_r), 32'h0F);
        in_valid = 1'b1;
        in_a = 8'h20;
        in_b = 8'h02;
        in_op = 2'b01;
        step();
        step();
        chk("bp_full_ready", 32'(in_ready), 32'(0));
        chk("bp_full_count", 32'(count), 32'(4));
        chk("bp_stable_r", 32'(out_r), 32'h0F);
        // Release: pop only while full, then push and pop together.
        out_ready = 1'b1;
        #1;
        chk("full_no_bypass", 32'(in_ready), 32'(0));
        step();
        chk("rel_count", 32'(count), 32'(3));
        chk("rel_ready", 32'(in_ready), 32'(1));
        chk("rel_r", 32'(out_r), 32'h11);
        step();
        chk("pp_count", 32'(count), 32'(3));
        chk("pp_r", 32'(out_r), 32'h55);
        in_valid = 1'b0;
        repeat (6) step();
        chk("bp_done_valid", 32'(out_valid), 32'(0));
        chk("bp_done_count", 32'(count), 32'(0));
        chk("bp_last_r", 32'(out_r), 32'h22);

        // Reset with pending work discards everything.
        out_ready = 1'b0;
        push_one(8'h0F, 8'h0F, 2'b00);
        push_one(8'h01, 8'h02, 2'b01);
        push_one(8'h03, 8'h01, 2'b10);
        push_one(8'h11, 8'h22, 2'b01);
        chk("mid_count", 32'(count), 32'(3));
        chk("mid_valid", 32'(out_valid), 32'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_ready", 32'(in_ready), 32'(0));
        step();
        rst = 1'b0;
        chk("mid_after_valid", 32'(out_valid), 32'(0));
        chk("mid_after_count", 32'(count), 32'(0));
        chk("mid_after_r", 32'(out_r), 32'(0));
        #1;
        chk("mid_after_ready", 32'(in_ready), 32'(1));
        out_ready = 1'b1;
        repeat (4) step();
        chk("no_stale", 32'(out_valid), 32'(0));

`ifdef LOGIC_OP_PARITY_EN
        push_one(8'h07, 8'h00, 2'b01);
        push_one(8'h03, 8'h00, 2'b10);
        chk("par_or_r", 32'(out_r), 32'h07);
        chk("par_or_p", 32'(out_parity), 32'(1));
        step();
        chk("par_xor_r", 32'(out_r), 32'h03);
        chk("par_xor_p", 32'(out_parity), 32'(0));
        step();
`endif

        step();
        running = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
